// File: rtl/ball_pkg.sv
// Shared constants and state type for the per-ball motion stage.
package ball_pkg;

    localparam int FIXED_POINT_MULTIPLIER = 64;
    localparam int FPM_SHIFT              = $clog2(FIXED_POINT_MULTIPLIER);
    localparam int MAX_SPEED              = 512;

    typedef enum logic [1:0] {
        IDLE,
        MOVING,
        SUNK
    } ball_state_t;

endpackage

// File: rtl/velocity_friction.sv
// One-axis friction decay followed by a symmetric speed clamp (combinational).
module velocity_friction #(
    parameter int FRICTION  = 1,
    parameter int MAX_SPEED = ball_pkg::MAX_SPEED
) (
    input  logic signed [31:0] vel,
    output logic signed [31:0] vel_new
);

    localparam logic signed [31:0] FRIC = 32'(FRICTION);
    localparam logic signed [31:0] LIM  = 32'(MAX_SPEED);

    logic signed [31:0] decayed;

    always_comb begin
        decayed = '0;
        // Range test avoids taking |v|, which overflows for the most negative value.
        if (vel <= FRIC && vel >= -FRIC) begin
            decayed = '0;
        end else if (vel > 0) begin
            decayed = vel - FRIC;
        end else begin
            decayed = vel + FRIC;
        end

        if (decayed > LIM) begin
            vel_new = LIM;
        end else if (decayed < -LIM) begin
            vel_new = -LIM;
        end else begin
            vel_new = decayed;
        end
    end

endmodule

// File: rtl/ball_move_ctrl.sv
// Per-ball motion: captures shots/collisions, applies friction once per frame and
// integrates fixed-point position; handles pocketing and respawn.
module ball_move_ctrl
    import ball_pkg::*;
#(
    parameter int INITIAL_X              = 280,
    parameter int INITIAL_Y              = 185,
    parameter int FIXED_POINT_MULTIPLIER = ball_pkg::FIXED_POINT_MULTIPLIER,
    parameter int FRICTION               = 1,
    parameter int MAX_SPEED              = ball_pkg::MAX_SPEED
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               collision,
    input  logic signed [31:0] nxt_vx,
    input  logic signed [31:0] nxt_vy,
    input  logic               shot_valid,
    input  logic signed [31:0] shot_vx,
    input  logic signed [31:0] shot_vy,
    input  logic               in_hole,
    input  logic               respawn,
    output logic signed [31:0] topLeftX,
    output logic signed [31:0] topLeftY,
    output logic signed [31:0] vx,
    output logic signed [31:0] vy,
    output logic               moving,
    output logic               sunk
);

    localparam int                 SHIFT = $clog2(FIXED_POINT_MULTIPLIER);
    localparam logic signed [31:0] X0    = 32'(INITIAL_X * FIXED_POINT_MULTIPLIER);
    localparam logic signed [31:0] Y0    = 32'(INITIAL_Y * FIXED_POINT_MULTIPLIER);

    ball_state_t        state;
    logic signed [31:0] x_fp, y_fp;
    logic signed [31:0] col_vx, col_vy, shot_vx_q, shot_vy_q;
    logic               pend_col, pend_shot;
    logic signed [31:0] src_vx, src_vy, vx_new, vy_new;

    always_comb begin
        src_vx = vx;
        src_vy = vy;
        if (collision) begin
            src_vx = nxt_vx;
            src_vy = nxt_vy;
        end else if (pend_col) begin
            src_vx = col_vx;
            src_vy = col_vy;
        end else if (pend_shot) begin
            src_vx = shot_vx_q;
            src_vy = shot_vy_q;
        end
    end

    velocity_friction #(.FRICTION(FRICTION), .MAX_SPEED(MAX_SPEED)) u_fric_x (
        .vel     (src_vx),
        .vel_new (vx_new)
    );

    velocity_friction #(.FRICTION(FRICTION), .MAX_SPEED(MAX_SPEED)) u_fric_y (
        .vel     (src_vy),
        .vel_new (vy_new)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            x_fp      <= X0;
            y_fp      <= Y0;
            vx        <= '0;
            vy        <= '0;
            col_vx    <= '0;
            col_vy    <= '0;
            shot_vx_q <= '0;
            shot_vy_q <= '0;
            pend_col  <= 1'b0;
            pend_shot <= 1'b0;
        end else if (respawn) begin
            state     <= IDLE;
            x_fp      <= X0;
            y_fp      <= Y0;
            vx        <= '0;
            vy        <= '0;
            pend_col  <= 1'b0;
            pend_shot <= 1'b0;
        end else if (state != SUNK) begin
            if (in_hole) begin
                state     <= SUNK;
                vx        <= '0;
                vy        <= '0;
                pend_col  <= 1'b0;
                pend_shot <= 1'b0;
            end else if (startOfFrame) begin
                vx        <= vx_new;
                vy        <= vy_new;
                x_fp      <= x_fp + vx_new;
                y_fp      <= y_fp + vy_new;
                state     <= (vx_new != 0 || vy_new != 0) ? MOVING : IDLE;
                pend_col  <= 1'b0;
                pend_shot <= 1'b0;
            end else begin
                if (collision) begin
                    col_vx   <= nxt_vx;
                    col_vy   <= nxt_vy;
                    pend_col <= 1'b1;
                end
                // A strike is only taken on a resting ball with no queued collision.
                if (shot_valid && state == IDLE && !pend_col) begin
                    shot_vx_q <= shot_vx;
                    shot_vy_q <= shot_vy;
                    pend_shot <= 1'b1;
                end
            end
        end
    end

    assign topLeftX = x_fp >>> SHIFT;
    assign topLeftY = y_fp >>> SHIFT;
    assign moving   = (state == MOVING);
    assign sunk     = (state == SUNK);

endmodule

// File: tb/tb_ball_move_ctrl.sv
// Directed plus randomized check of ball_move_ctrl against a behavioural model.
module tb_ball_move_ctrl;

    localparam int IX  = 280;
    localparam int IY  = 185;
    localparam int FPM = 64;
    localparam int FR  = 1;
    localparam int MS  = 512;

    logic clk = 1'b0;
    logic resetN, startOfFrame, collision, shot_valid, in_hole, respawn;
    logic signed [31:0] nxt_vx, nxt_vy, shot_vx, shot_vy;
    logic signed [31:0] topLeftX, topLeftY, vx, vy;
    logic moving, sunk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    // Model: ball status as 0 rest, 1 rolling, 2 pocketed.
    int m_x, m_y, m_vx, m_vy, m_st;
    bit m_pc, m_ps;
    int m_cvx, m_cvy, m_svx, m_svy;

    ball_move_ctrl dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .collision    (collision),
        .nxt_vx       (nxt_vx),
        .nxt_vy       (nxt_vy),
        .shot_valid   (shot_valid),
        .shot_vx      (shot_vx),
        .shot_vy      (shot_vy),
        .in_hole      (in_hole),
        .respawn      (respawn),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .vx           (vx),
        .vy           (vy),
        .moving       (moving),
        .sunk         (sunk)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int fric(input int v);
        int r;
        if (v >= -FR && v <= FR) r = 0;
        else if (v > 0) r = v - FR;
        else r = v + FR;
        if (r > MS) r = MS;
        if (r < -MS) r = -MS;
        return r;
    endfunction

    function automatic int pix(input int p);
        // Floor division by the sub-pixel scale.
        int q;
        q = p / FPM;
        if (p < 0 && q * FPM != p) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        m_x = IX * FPM; m_y = IY * FPM; m_vx = 0; m_vy = 0; m_st = 0;
        m_pc = 0; m_ps = 0; m_cvx = 0; m_cvy = 0; m_svx = 0; m_svy = 0;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("topLeftX", topLeftX, pix(m_x));
            chk("topLeftY", topLeftY, pix(m_y));
            chk("vx", vx, m_vx);
            chk("vy", vy, m_vy);
            chk("moving", {31'd0, moving}, (m_st == 1) ? 1 : 0);
            chk("sunk", {31'd0, sunk}, (m_st == 2) ? 1 : 0);
        end
    end

    task automatic clear_inputs();
        startOfFrame = 0; collision = 0; shot_valid = 0; in_hole = 0; respawn = 0;
        nxt_vx = 0; nxt_vy = 0; shot_vx = 0; shot_vy = 0;
    endtask

    // Advance one clock: predict from current inputs, then apply at the edge.
    task automatic tick();
        int nx, ny, nvx, nvy, nst, ncvx, ncvy, nsvx, nsvy, sx, sy;
        bit npc, nps;
        nx = m_x; ny = m_y; nvx = m_vx; nvy = m_vy; nst = m_st;
        npc = m_pc; nps = m_ps; ncvx = m_cvx; ncvy = m_cvy; nsvx = m_svx; nsvy = m_svy;
        if (respawn) begin
            nx = IX * FPM; ny = IY * FPM; nvx = 0; nvy = 0; nst = 0; npc = 0; nps = 0;
        end else if (m_st == 2) begin
            // pocketed ball ignores everything else
        end else if (in_hole) begin
            nst = 2; nvx = 0; nvy = 0; npc = 0; nps = 0;
        end else if (startOfFrame) begin
            if (collision) begin sx = nxt_vx; sy = nxt_vy; end
            else if (m_pc) begin sx = m_cvx; sy = m_cvy; end
            else if (m_ps) begin sx = m_svx; sy = m_svy; end
            else begin sx = m_vx; sy = m_vy; end
            nvx = fric(sx); nvy = fric(sy);
            nx = m_x + nvx; ny = m_y + nvy;
            nst = (nvx != 0 || nvy != 0) ? 1 : 0;
            npc = 0; nps = 0;
        end else begin
            if (collision) begin ncvx = nxt_vx; ncvy = nxt_vy; npc = 1; end
            if (shot_valid && m_st == 0 && !m_pc) begin nsvx = shot_vx; nsvy = shot_vy; nps = 1; end
        end
        @(posedge clk);
        m_x = nx; m_y = ny; m_vx = nvx; m_vy = nvy; m_st = nst;
        m_pc = npc; m_ps = nps; m_cvx = ncvx; m_cvy = ncvy; m_svx = nsvx; m_svy = nsvy;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic col(input int a, input int b);
        collision = 1; nxt_vx = a; nxt_vy = b; tick();
    endtask

    task automatic shot(input int a, input int b);
        shot_valid = 1; shot_vx = a; shot_vy = b; tick();
    endtask

    task automatic frame();
        startOfFrame = 1; tick();
    endtask

    function automatic int rvel();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 6)) - 3;
        return int'($urandom_range(0, 1400)) - 700;
    endfunction

    initial begin
        clear_inputs();
        resetN = 0;
        model_reset();
        repeat (2) @(negedge clk);
        resetN = 1;
        cmp_en = 1;
        chk("rst_x", topLeftX, 280);
        chk("rst_y", topLeftY, 185);
        chk("rst_vx", vx, 0);
        chk("rst_moving", {31'd0, moving}, 0);
        chk("rst_sunk", {31'd0, sunk}, 0);

        shot(128, 0);
        frame();
        chk("shot_vx", vx, 127);
        chk("shot_x", topLeftX, 281);
        chk("shot_y", topLeftY, 185);
        chk("shot_moving", {31'd0, moving}, 1);

        col(101, 0);
        frame();
        chk("pre_override_vx", vx, 100);
        col(-50, 30);
        frame();
        chk("override_vx", vx, -49);
        chk("override_vy", vy, 29);

        col(40, 0);
        collision = 1; nxt_vx = 200; nxt_vy = 0; startOfFrame = 1;
        tick();
        chk("same_cycle_vx", vx, 199);

        col(2, 0);
        frame();
        chk("slow_vx", vx, 1);
        frame();
        chk("stop_vx", vx, 0);
        chk("stop_moving", {31'd0, moving}, 0);

        col(50, 0);
        frame();
        shot(300, 300);
        frame();
        chk("guard_vx", vx, 48);
        chk("guard_vy", vy, 0);

        in_hole = 1; tick();
        chk("sink_sunk", {31'd0, sunk}, 1);
        chk("sink_vx", vx, 0);
        col(77, 5);
        shot(90, 90);
        frame();
        chk("sunk_vx", vx, 0);
        chk("sunk_hold", {31'd0, sunk}, 1);
        respawn = 1; tick();
        chk("resp_x", topLeftX, 280);
        chk("resp_y", topLeftY, 185);
        chk("resp_sunk", {31'd0, sunk}, 0);
        chk("resp_moving", {31'd0, moving}, 0);

        col(301, 0);
        frame();
        chk("pre_rst_vx", vx, 300);
        col(10, 10);
        #3 resetN = 0;
        model_reset();
        #1;
        chk("async_vx", vx, 0);
        chk("async_x", topLeftX, 280);
        chk("async_moving", {31'd0, moving}, 0);
        @(negedge clk);
        #2 resetN = 1;
        @(negedge clk);
        frame();
        chk("post_rst_vx", vx, 0);
        chk("post_rst_x", topLeftX, 280);
        chk("post_rst_y", topLeftY, 185);

        for (int i = 0; i < 3000; i++) begin
            startOfFrame = ($urandom_range(0, 3) == 0);
            collision    = ($urandom_range(0, 5) == 0);
            shot_valid   = ($urandom_range(0, 5) == 0);
            in_hole      = ($urandom_range(0, 79) == 0);
            respawn      = ($urandom_range(0, 99) == 0);
            nxt_vx = rvel(); nxt_vy = rvel();
            shot_vx = rvel(); shot_vy = rvel();
            tick();
        end

        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ball_move_ctrl.md
Name: ball_move_ctrl

Overview:
- Per-ball motion stage that consumes the selected collision velocity (collision, nxt_vx, nxt_vy) from the per-ball velocity selector.
- Holds fixed-point position and velocity. Once per frame it applies a shot, a collision or friction, then integrates position.
- Drives pixel-space topLeftX/topLeftY to the ball bitmap/draw stage and back into the collision modules.

Parameters:
- INITIAL_X, 280, reset/respawn X in pixels
- INITIAL_Y, 185, reset/respawn Y in pixels
- FIXED_POINT_MULTIPLIER, 64, sub-pixel scale; power of 2
- FRICTION, 1, per-frame speed decrement per axis, fixed-point units
- MAX_SPEED, 512, per-axis velocity magnitude clamp, fixed-point units

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per VGA frame
- collision  in  1  a selected collision velocity is valid this cycle
- nxt_vx  in  32 signed  selected collision X velocity, fixed-point
- nxt_vy  in  32 signed  selected collision Y velocity, fixed-point
- shot_valid  in  1  cue strike pulse
- shot_vx  in  32 signed  cue strike X velocity, fixed-point
- shot_vy  in  32 signed  cue strike Y velocity, fixed-point
- in_hole  in  1  ball entered a pocket (pulse)
- respawn  in  1  return ball to the initial position (pulse)
- topLeftX  out  32 signed  pixel X
- topLeftY  out  32 signed  pixel Y
- vx  out  32 signed  current X velocity, fixed-point
- vy  out  32 signed  current Y velocity, fixed-point
- moving  out  1  state is MOVING
- sunk  out  1  state is SUNK

Behaviour:
- Reset (async, resetN=0):
  - x_fp=INITIAL_X*FPM, y_fp=INITIAL_Y*FPM, vx=vy=0.
  - state IDLE, pending flags cleared.
  - topLeftX=INITIAL_X, topLeftY=INITIAL_Y, moving=0, sunk=0.
- Reset mid-motion discards all pending shots and collisions.
- States: IDLE (stationary), MOVING, SUNK.
- Collision capture:
  - Any cycle with collision=1 latches nxt_vx/nxt_vy and sets pend_col.
  - Last capture before the frame update wins.
  - Captures are ignored in SUNK.
- Shot capture:
  - shot_valid is accepted only in IDLE with no pend_col. It latches shot_vx/shot_vy and sets pend_shot.
  - It is ignored in MOVING and SUNK.
- Frame update, on the startOfFrame cycle, applies only in IDLE/MOVING:
  - Source velocity priority:
    1. Collision this same cycle (use nxt_* directly).
    2. pend_col.
    3. pend_shot.
    4. Current vx/vy.
  - Per axis: if |v| <= FRICTION then 0, else v - sign(v)*FRICTION. Then clamp to +/-MAX_SPEED.
  - Position: x_fp += vx_new, y_fp += vy_new, using 32-bit signed arithmetic. No wall handling here; walls arrive as collisions.
  - Both pending flags clear.
  - Next state is MOVING if either vx_new or vy_new is nonzero, else IDLE.
  - A zero-velocity collision in IDLE leaves the ball in IDLE.
- Latency: registers update on the startOfFrame edge, so outputs reflect the new frame one clock after the pulse. They are stable for the rest of the frame.
- topLeftX = x_fp >>> log2(FPM), an arithmetic shift (floor). topLeftY is computed the same way.
- in_hole (any state other than SUNK):
  - Next cycle: state SUNK, vx=vy=0, pending flags cleared, position frozen.
  - Takes priority over a simultaneous frame update.
- respawn:
  - Next cycle: position set to the initial values, velocity 0, state IDLE.
  - Highest priority, including over in_hole.
- In SUNK, nothing changes except through respawn or reset.
- moving and sunk are direct state decodes (registered).

Decomposition:
- Shared package ball_pkg holds:
  - FIXED_POINT_MULTIPLIER and FPM_SHIFT constants.
  - The ball_state_t enum {IDLE, MOVING, SUNK}.
  - The MAX_SPEED default.
- One natural sub-module, velocity_friction: combinational friction plus clamp for one axis, instantiated twice (X and Y).

Test Plan:
- Shot from rest: reset, then shot_valid with shot_vx=128, shot_vy=0, then startOfFrame -> vx=127, topLeftX=281 (17920+127=18047, >>>6), topLeftY=185, moving=1.
- Collision override: ball MOVING with vx=100, vy=0; collision with nxt_vx=-50, nxt_vy=30 mid-frame, then startOfFrame -> vx=-49, vy=29.
- Collision coincident with startOfFrame, nxt_vx=200 (pend_col holding 40) -> vx=199, because same-cycle collision wins.
- Stop and guard:
  - Ball with vx=1, vy=0; startOfFrame -> vx=0, moving=0, IDLE.
  - A shot_valid during MOVING is ignored: velocity after the next frame is the friction-decayed value.
- Sink and respawn:
  - in_hole -> sunk=1, vx=vy=0. Subsequent collision and shot inputs cause no change.
  - respawn -> topLeftX=280, topLeftY=185, sunk=0, IDLE.
- Reset mid-motion: resetN=0 while vx=300 with pend_col set -> outputs reach their reset values immediately. After release and the next startOfFrame, vx=0 and position is unchanged.
